// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: shared types and constants for the two-way traffic light.
//   state_e    : phase of the intersection (which direction is green/yellow)
//   SEG_0..9   : 7-segment codes, active-low, bit6..0 = g..a
//   SEG_BLANK  : all segments off, used for out-of-range digits
package traffic_light_pkg;

  typedef enum logic [1:0] {
    G1R2 = 2'd0,
    Y1R2 = 2'd1,
    R1G2 = 2'd2,
    R1Y2 = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/traffic_light_if.sv
// traffic_light_if: bundle of everything the light drives -- four 7-segment
// digits and six lamps. The light side uses the master modport, observers
// (display board, bench monitors) use the slave modport.
//   hex0/hex1 : direction-1 ones/tens digit      hex2/hex3 : direction-2 ones/tens
//   lr1/ly1/lg1, lr2/ly2/lg2 : lamps, active-high
interface traffic_light_if;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       lr1, ly1, lg1;
  logic       lr2, ly2, lg2;

  modport master (output hex0, hex1, hex2, hex3, lr1, ly1, lg1, lr2, ly2, lg2);
  modport slave  (input  hex0, hex1, hex2, hex3, lr1, ly1, lg1, lr2, ly2, lg2);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD digit to active-low 7-segment pattern (g..a).
//   digit_i : 4-bit digit, 0..9 (anything else blanks the display)
//   seg_o   : segments, active-low, bit6..0 = g..a
module seg7_decoder
  import traffic_light_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/traffic_light.sv
// traffic_light: two-direction intersection controller with per-direction
// seconds countdown on 7-segment displays.
//   clk50M          : system clock, rising edge
//   Reset           : asynchronous active-high reset
//   HEX1/HEX0       : direction-1 countdown tens/ones, active-low g..a
//   HEX3/HEX2       : direction-2 countdown tens/ones, active-low g..a
//   LR1/LY1/LG1     : direction-1 lamps, active-high
//   LR2/LY2/LG2     : direction-2 lamps, active-high
// All outputs are a pure decode of registered state/rem, so an async reset
// shows up on the outputs immediately.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int GREEN_S  = 25,
  parameter int YELLOW_S = 3
) (
  input  logic       clk50M,
  input  logic       Reset,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       LR1,
  output logic       LY1,
  output logic       LG1,
  output logic       LR2,
  output logic       LY2,
  output logic       LG2
);

  localparam int             CW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_HZ - 1);
  localparam logic [6:0]     G7      = 7'(GREEN_S);
  localparam logic [6:0]     Y7      = 7'(YELLOW_S);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  state_e        state_q, state_d;
  logic [6:0]    rem_q, rem_d;

  // one-second prescaler
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk50M or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      state_q <= G1R2;
      rem_q   <= G7;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // phase sequencing: rem counts down to 1, then the next phase loads its length
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (tick) begin
      if (rem_q > 7'd1) begin
        rem_d = rem_q - 7'd1;
      end else begin
        case (state_q)
          G1R2:    begin state_d = Y1R2; rem_d = Y7; end
          Y1R2:    begin state_d = R1G2; rem_d = G7; end
          R1G2:    begin state_d = R1Y2; rem_d = Y7; end
          R1Y2:    begin state_d = G1R2; rem_d = G7; end
          default: begin state_d = G1R2; rem_d = G7; end
        endcase
      end
    end
  end

  // lamps and displayed values; a red side facing green still has the
  // other side's yellow ahead of it, hence rem + YELLOW_S
  logic [6:0] disp1, disp2;

  always_comb begin
    {LR1, LY1, LG1, LR2, LY2, LG2} = 6'b000_000;
    disp1 = rem_q;
    disp2 = rem_q;
    case (state_q)
      G1R2: begin
        {LG1, LR2} = 2'b11;
        disp2      = rem_q + Y7;
      end
      Y1R2: {LY1, LR2} = 2'b11;
      R1G2: begin
        {LR1, LG2} = 2'b11;
        disp1      = rem_q + Y7;
      end
      R1Y2: {LR1, LY2} = 2'b11;
      default: {LG1, LR2} = 2'b11;
    endcase
  end

  logic [3:0] d1_tens, d1_ones, d2_tens, d2_ones;

  always_comb begin
    d1_tens = 4'(disp1 / 7'd10);
    d1_ones = 4'(disp1 % 7'd10);
    d2_tens = 4'(disp2 / 7'd10);
    d2_ones = 4'(disp2 % 7'd10);
  end

  seg7_decoder u_hex0 (.digit_i(d1_ones), .seg_o(HEX0));
  seg7_decoder u_hex1 (.digit_i(d1_tens), .seg_o(HEX1));
  seg7_decoder u_hex2 (.digit_i(d2_ones), .seg_o(HEX2));
  seg7_decoder u_hex3 (.digit_i(d2_tens), .seg_o(HEX3));

endmodule

// File: tb/tb_traffic_light.sv
module tb_traffic_light;

  localparam int HZ = 10;

  logic clk50M = 1'b0;
  logic Reset  = 1'b1;
  always #5 clk50M = ~clk50M;

  traffic_light_if ifa ();
  traffic_light_if ifb ();

  traffic_light #(.CLK_HZ(HZ), .GREEN_S(5), .YELLOW_S(2)) u_dut (
    .clk50M(clk50M), .Reset(Reset),
    .HEX0(ifa.hex0), .HEX1(ifa.hex1), .HEX2(ifa.hex2), .HEX3(ifa.hex3),
    .LR1(ifa.lr1), .LY1(ifa.ly1), .LG1(ifa.lg1),
    .LR2(ifa.lr2), .LY2(ifa.ly2), .LG2(ifa.lg2)
  );

  traffic_light #(.CLK_HZ(HZ), .GREEN_S(90), .YELLOW_S(9)) u_big (
    .clk50M(clk50M), .Reset(Reset),
    .HEX0(ifb.hex0), .HEX1(ifb.hex1), .HEX2(ifb.hex2), .HEX3(ifb.hex3),
    .LR1(ifb.lr1), .LY1(ifb.ly1), .LG1(ifb.lg1),
    .LR2(ifb.lr2), .LY2(ifb.ly2), .LG2(ifb.lg2)
  );

  typedef struct packed {
    logic [33:0] a;
    logic [33:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;   // clock edges since reset release

  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // expected outputs after n edges, from elapsed seconds within the cycle
  function automatic logic [33:0] model(int edges, int g, int y);
    int p, rem, d1, d2;
    logic [5:0] lamps;
    p = (edges / HZ) % (2 * (g + y));
    if (p < g) begin
      rem = g - p; d1 = rem; d2 = rem + y; lamps = 6'b001_100;
    end else if (p < g + y) begin
      rem = g + y - p; d1 = rem; d2 = rem; lamps = 6'b010_100;
    end else if (p < 2 * g + y) begin
      rem = 2 * g + y - p; d1 = rem + y; d2 = rem; lamps = 6'b100_001;
    end else begin
      rem = 2 * (g + y) - p; d1 = rem; d2 = rem; lamps = 6'b100_010;
    end
    return {segs[d2 / 10], segs[d2 % 10], segs[d1 / 10], segs[d1 % 10], lamps};
  endfunction

  function automatic logic [33:0] obs_a();
    return {ifa.hex3, ifa.hex2, ifa.hex1, ifa.hex0,
            ifa.lr1, ifa.ly1, ifa.lg1, ifa.lr2, ifa.ly2, ifa.lg2};
  endfunction

  function automatic logic [33:0] obs_b();
    return {ifb.hex3, ifb.hex2, ifb.hex1, ifb.hex0,
            ifb.lr1, ifb.ly1, ifb.lg1, ifb.lr2, ifb.ly2, ifb.lg2};
  endfunction

  task automatic push_exp();
    exp_t e;
    e.a = model(n, 5, 2);
    e.b = model(n, 90, 9);
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_a"}, 64'(obs_a()), 64'(e.a));
    chk({tag, "_b"}, 64'(obs_b()), 64'(e.b));
    // exactly one lamp per direction
    chk({tag, "_oh1"}, 64'($countones({ifa.lr1, ifa.ly1, ifa.lg1})), 64'd1);
    chk({tag, "_oh2"}, 64'($countones({ifa.lr2, ifa.ly2, ifa.lg2})), 64'd1);
  endtask

  task automatic run(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(posedge clk50M);
      n++;
      push_exp();
      @(negedge clk50M);
      pop_chk(tag);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge clk50M);
    n = 0;
    push_exp();
    pop_chk("reset");
    Reset = 1'b0;
  endtask

  initial begin
    do_reset();
    // fixed reset values, written out literally
    chk("rst_hex1", 64'(ifa.hex1), 64'(7'b1000000));
    chk("rst_hex0", 64'(ifa.hex0), 64'(7'b0010010));
    chk("rst_hex3", 64'(ifa.hex3), 64'(7'b1000000));
    chk("rst_hex2", 64'(ifa.hex2), 64'(7'b1111000));
    chk("rst_big_hex3", 64'(ifb.hex3), 64'(7'b0010000));
    chk("rst_big_hex2", 64'(ifb.hex2), 64'(7'b0010000));

    run(10, "sec1");
    chk("s1_hex0", 64'(ifa.hex0), 64'(7'b0011001));   // 4
    chk("s1_hex2", 64'(ifa.hex2), 64'(7'b0000010));   // 6
    run(40, "grn");
    chk("y_ly1", 64'({ifa.ly1, ifa.lr2}), 64'(2'b11));
    chk("y_hex0", 64'(ifa.hex0), 64'(7'b0100100));    // 2
    chk("y_hex2", 64'(ifa.hex2), 64'(7'b0100100));    // 2
    run(40, "cycle");                                 // into R1G2

    // async reset mid R1G2, checked before the next clock edge
    @(posedge clk50M);
    n++;
    #2 Reset = 1'b1;
    #1;
    n = 0;
    push_exp();
    pop_chk("async_rst");
    chk("async_lg1", 64'({ifa.lg1, ifa.lr2, ifa.lr1, ifa.lg2}), 64'(4'b1100));
    repeat (2) @(negedge clk50M);
    Reset = 1'b0;
    n = 0;

    run(150, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/traffic_light.md
TRAFFIC_LIGHT -- requirements
Module: traffic_light

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: clock cycles per one-second tick; range 2..2^26.
REQ-002 Parameter GREEN_S, default 25: green phase length in seconds; range 1..96.
REQ-003 Parameter YELLOW_S, default 3: yellow phase length in seconds; range 1..(99-GREEN_S).
REQ-004 Ports, one clock; reset is asynchronous and active-high.
- clk50M  in  1  system clock, 50 MHz; rising edge.
- Reset  in  1  asynchronous active-high reset.
- HEX0  out  7  direction-1 countdown, ones digit, 7-segment active-low, bit6..0 = g..a.
- HEX1  out  7  direction-1 countdown, tens digit, same encoding.
- HEX2  out  7  direction-2 countdown, ones digit.
- HEX3  out  7  direction-2 countdown, tens digit.
- LR1, LY1, LG1  out  1 each  direction-1 red/yellow/green lamp, active-high.
- LR2, LY2, LG2  out  1 each  direction-2 red/yellow/green lamp, active-high.

Function
REQ-005 Prescaler SHALL count 0..CLK_HZ-1 and wrap; a one-cycle tick SHALL assert in the cycle the count equals CLK_HZ-1.
REQ-006 FSM states and lamps:
- G1R2: LG1, LR2.
- Y1R2: LY1, LR2.
- R1G2: LR1, LG2.
- R1Y2: LR1, LY2.
- Exactly one lamp per direction SHALL be on at all times.
REQ-007 Phase counter rem SHALL be loaded with GREEN_S on entry to a green state and YELLOW_S on entry to a yellow state.
REQ-008 On tick with rem>1: rem decrements. On tick with rem==1: FSM advances G1R2->Y1R2->R1G2->R1Y2->G1R2 and rem is loaded for the new state in the same cycle.
REQ-009 Full cycle length SHALL be 2*(GREEN_S+YELLOW_S) seconds; default 56 s.
REQ-010 Displayed value, per direction:
- Green or yellow direction shows rem.
- Red direction shows rem+YELLOW_S while the other direction is green, and rem while it is yellow.
REQ-011 Display value SHALL be split into tens and ones (0..99); the tens digit SHALL always be driven, with a leading zero shown.
REQ-012 Segment codes, active-low g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-013 Lamps and HEX outputs SHALL be registered or pure decode of registered state/rem; they SHALL update the cycle after the tick edge and SHALL be glitch-free between ticks.

Reset
REQ-014 While Reset=1:
- FSM=G1R2, rem=GREEN_S, prescaler=0.
- Lamps: LG1=1, LR2=1, all others 0.
- Display: HEX1/HEX0 show GREEN_S, HEX3/HEX2 show GREEN_S+YELLOW_S (defaults 25 and 28).
REQ-015 Reset asserted mid-phase SHALL take effect immediately, without waiting for a clock edge; after release, the first tick SHALL occur CLK_HZ cycles later.

Structure
REQ-016 Package traffic_light_pkg SHALL hold the state enum and the ten segment constants.
REQ-017 A single sub-module seg7_decoder (4-bit digit in, 7-bit active-low segments out) SHALL be instantiated four times; all other logic SHALL reside in traffic_light.

Verification
All scenarios use CLK_HZ=10, GREEN_S=5, YELLOW_S=2 unless noted.
REQ-018 Reset pulse -> LG1=LR2=1, HEX1/HEX0=0/5 (1000000/0010010), HEX3/HEX2=0/7 (1000000/1111000).
REQ-019 Run 10 cycles after reset -> direction 1 shows 4 and direction 2 shows 6; after 50 cycles from reset -> Y1R2, both directions show 2.
REQ-020 Run 140 cycles -> full sequence G1R2(50), Y1R2(20), R1G2(50), R1Y2(20), back to G1R2; lamps one-hot per direction every cycle.
REQ-021 Assert Reset asynchronously mid-R1G2 -> outputs return to reset values before the next clock edge; sequence restarts from G1R2.
REQ-022 GREEN_S=90, YELLOW_S=9 -> red side shows 99 (HEX3=0010000, HEX2=0010000) at reset.
